// File: rtl/multi_priority_encoder.sv
// Handshaked multi-slot priority encoder: accepts an N-bit request vector and
// extracts up to K highest-priority set bits, one per clock, as 1-based indices.
module multi_priority_encoder #(
  parameter  int N  = 12,
  parameter  int K  = 2,
  localparam int IW = $clog2(N + 1),
  localparam int CW = $clog2(K + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    r,
  input  logic            lsb_first,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [K*IW-1:0] p,
  output logic [CW-1:0]   found,
  output logic            more
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e          state_q;
  logic [N-1:0]    work_q;
  logic            mode_q;
  logic [CW-1:0]   k_q;
  logic [K*IW-1:0] p_q;
  logic [CW-1:0]   found_q;
  logic            more_q;

  logic [IW-1:0]   sel_idx;
  logic [N-1:0]    sel_oh;
  logic [N-1:0]    work_clr;
  logic [CW-1:0]   k_inc;

  // Later hits overwrite earlier ones, so the scan order puts the
  // highest-priority bit last for the selected direction.
  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mode_q) begin
        if (work_q[N-1-i]) begin
          sel_idx         = IW'(N - 1 - i);
          sel_oh          = '0;
          sel_oh[N-1-i]   = 1'b1;
        end
      end else if (work_q[i]) begin
        sel_idx   = IW'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    work_clr = work_q & ~sel_oh;
    k_inc    = k_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
      p_q     <= '0;
      found_q <= '0;
      more_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= r;
            mode_q  <= lsb_first;
            k_q     <= '0;
            p_q     <= '0;
            found_q <= '0;
            more_q  <= 1'b0;
            state_q <= (r != '0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          for (int unsigned s = 0; s < K; s++) begin
            if (k_q == CW'(s)) p_q[s*IW +: IW] <= sel_idx + 1'b1;
          end
          work_q  <= work_clr;
          k_q     <= k_inc;
          found_q <= k_inc;
          if (k_inc == CW'(K) || work_clr == '0) begin
            state_q <= DONE;
            more_q  <= (work_clr != '0);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;
  assign found     = found_q;
  assign more      = more_q;

endmodule

// File: tb/tb_multi_priority_encoder.sv
// Self-checking bench for multi_priority_encoder: three configurations driven
// by a directed vector table, hand-written corner sequences and random traffic.
module tb_multi_priority_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [15:0] r;
  logic        lsb_first;

  logic        ir0, ir1, ir2, ov0, ov1, ov2, m0, m1, m2;
  logic [7:0]  p0;
  logic [19:0] p1;
  logic [47:0] p2;
  logic [1:0]  f0;
  logic [2:0]  f1;
  logic [3:0]  f2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_priority_encoder #(.N(12), .K(2)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(ir0),
    .r(r[11:0]), .lsb_first(lsb_first), .out_valid(ov0), .out_ready(out_ready[0]),
    .p(p0), .found(f0), .more(m0));

  multi_priority_encoder #(.N(16), .K(4)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(ir1),
    .r(r), .lsb_first(lsb_first), .out_valid(ov1), .out_ready(out_ready[1]),
    .p(p1), .found(f1), .more(m1));

  multi_priority_encoder #(.N(12), .K(12)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(ir2),
    .r(r[11:0]), .lsb_first(lsb_first), .out_valid(ov2), .out_ready(out_ready[2]),
    .p(p2), .found(f2), .more(m2));

  function automatic int cfg_n(input int w);
    return (w == 1) ? 16 : 12;
  endfunction
  function automatic int cfg_k(input int w);
    return (w == 0) ? 2 : (w == 1) ? 4 : 12;
  endfunction
  function automatic int cfg_iw(input int w);
    return (w == 1) ? 5 : 4;
  endfunction

  function automatic logic get_ir(input int w);
    return (w == 0) ? ir0 : (w == 1) ? ir1 : ir2;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 0) ? ov0 : (w == 1) ? ov1 : ov2;
  endfunction
  function automatic logic get_m(input int w);
    return (w == 0) ? m0 : (w == 1) ? m1 : m2;
  endfunction
  function automatic logic [63:0] get_p(input int w);
    return (w == 0) ? 64'(p0) : (w == 1) ? 64'(p1) : 64'(p2);
  endfunction
  function automatic logic [63:0] get_f(input int w);
    return (w == 0) ? 64'(f0) : (w == 1) ? 64'(f1) : 64'(f2);
  endfunction

  // Reference: list set bits in priority order, keep the first k.
  function automatic void model(input logic [15:0] rv, input int n, input int k,
                                input int iw, input bit lsb,
                                output logic [63:0] ep, output int ef,
                                output bit em, output int lat);
    int order[$];
    ep = '0;
    for (int j = 0; j < n; j++) begin
      int b;
      b = lsb ? j : n - 1 - j;
      if (rv[b]) order.push_back(b + 1);
    end
    ef = (order.size() < k) ? order.size() : k;
    for (int s = 0; s < ef; s++) ep |= 64'(order[s]) << (s * iw);
    em  = (order.size() > k);
    lat = ef + 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_reset(input int w, input string nm);
    check({nm, ".in_ready"},  64'(get_ir(w)), 64'd1);
    check({nm, ".out_valid"}, 64'(get_ov(w)), 64'd0);
    check({nm, ".p"},         get_p(w),       64'd0);
    check({nm, ".found"},     get_f(w),       64'd0);
    check({nm, ".more"},      64'(get_m(w)),  64'd0);
  endtask

  // Waits for out_valid after the accept edge; returns the edge count,
  // counting the accept edge itself as 1.
  task automatic wait_valid(input int w, input bit scramble, output int cyc);
    cyc = 1;
    while (!get_ov(w) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (scramble) begin
        lsb_first = 1'($urandom);
        r         = 16'($urandom);
      end
    end
  endtask

  task automatic run_txn(input int w, input logic [15:0] rv, input bit lsb,
                         input bit early, input logic [63:0] ep, input int ef,
                         input bit em, input int el, input string nm);
    int cyc;
    cyc = 0;
    while (!get_ir(w) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) check({nm, ".ready_timeout"}, 64'(get_ir(w)), 64'd1);
    @(negedge clk);
    r = rv; lsb_first = lsb; in_valid[w] = 1'b1;
    @(posedge clk); #1;
    in_valid[w] = 1'b0;
    r = 16'($urandom); lsb_first = ~lsb;
    if (early) out_ready[w] = 1'b1;
    wait_valid(w, 1'b1, cyc);
    check({nm, ".latency"}, 64'(cyc), 64'(el));
    check({nm, ".p"},       get_p(w), ep);
    check({nm, ".found"},   get_f(w), 64'(ef));
    check({nm, ".more"},    64'(get_m(w)), 64'(em));
    @(negedge clk);
    out_ready[w] = 1'b1;
    @(posedge clk); #1;
    out_ready[w] = 1'b0;
    check({nm, ".idle_after"}, {62'd0, get_ir(w), get_ov(w)}, 64'b10);
  endtask

  typedef struct {
    int          w;
    logic [15:0] r;
    bit          lsb;
    logic [63:0] ep;
    int          ef;
    bit          em;
    int          el;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    logic [63:0] ep;
    int          ef, el, cyc, w;
    bit          em;
    logic [15:0] rv;
    bit          lsb;

    tbl[0] = '{0, 16'h0A8, 1'b0, 64'h68,           2,  1'b1, 3};
    tbl[1] = '{0, 16'h0A8, 1'b1, 64'h64,           2,  1'b1, 3};
    tbl[2] = '{0, 16'h801, 1'b0, 64'h1C,           2,  1'b0, 3};
    tbl[3] = '{0, 16'h801, 1'b1, 64'hC1,           2,  1'b0, 3};
    tbl[4] = '{0, 16'h000, 1'b0, 64'h0,            0,  1'b0, 1};
    tbl[5] = '{0, 16'h080, 1'b0, 64'h08,           1,  1'b0, 2};
    tbl[6] = '{2, 16'hFFF, 1'b0, 64'h123456789ABC, 12, 1'b0, 13};
    tbl[7] = '{2, 16'hFFF, 1'b1, 64'hCBA987654321, 12, 1'b0, 13};

    reset_n = 1'b0; in_valid = '0; out_ready = '0; r = '0; lsb_first = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_idle_reset(i, $sformatf("rst%0d", i));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].w, tbl[i].r, tbl[i].lsb, 1'(i % 2), tbl[i].ep, tbl[i].ef,
              tbl[i].em, tbl[i].el, $sformatf("vec%0d", i));

    // Backpressure: DONE held with a competing request pending
    @(negedge clk);
    r = 16'h0A8; lsb_first = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_valid(0, 1'b0, cyc);
    check("bp.latency", 64'(cyc), 64'd3);
    @(negedge clk);
    r = 16'h011; lsb_first = 1'b1; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", i), {52'd0, ir0, ov0, p0, f0, m0}, {52'd0, 2'b01, 8'h68, 2'd2, 1'b1});
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp.idle", {62'd0, ir0, ov0}, 64'b10);
    check("bp.kept", {53'd0, p0, f0, m0}, {53'd0, 8'h68, 2'd2, 1'b1});
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp.accepted", 64'(ir0), 64'd0);
    wait_valid(0, 1'b0, cyc);
    check("bp.new_lat", 64'(cyc), 64'd3);
    check("bp.new_res", {53'd0, p0, f0, m0}, {53'd0, 8'h51, 2'd2, 1'b0});
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Asynchronous reset in the middle of a scan
    @(negedge clk);
    r = 16'hFFFF; lsb_first = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_reset(1, "midscan");
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(1, 16'h8421, 1'b0, 1'b0, 64'h9970, 4, 1'b0, 5, "r8421");

    for (int it = 0; it < 60; it++) begin
      w  = $urandom_range(0, 2);
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv = rv & 16'($urandom) & 16'($urandom);
      if (cfg_n(w) == 12) rv = rv & 16'h0FFF;
      lsb = 1'($urandom);
      model(rv, cfg_n(w), cfg_k(w), cfg_iw(w), lsb, ep, ef, em, el);
      run_txn(w, rv, lsb, 1'($urandom), ep, ef, em, el, $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/multi_priority_encoder.md
# multi_priority_encoder

Parametrised, handshaked priority encoder. Accepts an N-bit request vector, then extracts the K highest-priority set bits one per clock. Reports each as a 1-based index, with 0 meaning none. Priority direction is selectable per transaction. It generalises the fixed 12-bit, two-output combinational dual priority encoder into a sequential engine with valid/ready flow control on both sides.

## Interface
- N, default 12: request vector width; N >= 2.
- K, default 2: number of result slots; 1 <= K <= N.
- IW, derived $clog2(N+1): width of one result slot.
- CW, derived $clog2(K+1): width of the found count.
- clk  input  1: single clock, rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: request vector presented.
- in_ready  output  1: engine idle and able to accept.
- r  input  N: request vector; sampled on accept.
- lsb_first  input  1: sampled on accept. 0 = bit N-1 highest priority; 1 = bit 0 highest.
- out_valid  output  1: result held and valid.
- out_ready  input  1: consumer takes result.
- p  output  K*IW: slot k is p[k*IW +: IW]; slot 0 is highest priority; value = bit index + 1; 0 = empty slot.
- found  output  CW: number of non-zero slots, 0..K.
- more  output  1: set bits remained after K were extracted.

## Operation
- States: IDLE, SCAN, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - Accept fires when in_valid && in_ready at the rising edge.
  - On accept: work <= r; mode <= lsb_first; k <= 0; all p slots <= 0; found <= 0; more <= 0.
  - Next state: SCAN if r != 0, otherwise DONE.
- SCAN, every cycle:
  - Select the highest-priority set bit i of work, according to mode.
  - p slot k <= i+1; clear bit i in work; k <= k+1; found <= k+1.
  - Go to DONE when k+1 == K or the cleared work == 0; otherwise stay in SCAN.
  - On the transition to DONE: more <= 1 iff the cleared work != 0.
- DONE:
  - p, found and more are held stable while out_ready is low.
  - When out_valid && out_ready at the edge, go to IDLE.
  - p/found/more keep their values until the next accept.
- No accept is possible in SCAN or DONE; in_valid is ignored there.
- r and lsb_first are don't-care outside the accept edge.
- Reset, asynchronous and effective mid-transaction:
  - State goes to IDLE; work, k, p, found, more go to 0.
  - Any in-flight transaction is discarded and no partial result is presented.
- Output values during reset: in_ready = 1 (IDLE decode), out_valid = 0, p = 0, found = 0, more = 0.

## Timing
- Latency: out_valid rises min(K, popcount(r)) + 1 cycles after the accept edge. For r == 0 this is 1 cycle.
- out_valid stays high from then until the handshake edge.
- in_ready rises the cycle after the output handshake.
- Minimum transaction period: latency + 1 cycles, i.e. 1 IDLE cycle plus SCAN cycles plus at least 1 DONE cycle.
- Outputs come from registers. Priority selection is a combinational scan of work within one cycle; the critical path is an N-bit priority find plus an IW-bit encode.
- Boundary cases:
  - K == N with all bits set: N SCAN cycles, more = 0.
  - Single set bit: 1 SCAN cycle, found = 1, remaining slots 0.
  - lsb_first changing during SCAN has no effect.
  - out_ready high before out_valid has no effect.

## Test plan
- N=12, K=2, lsb_first=0, r=12'b000010101000 -> p slot0=8, slot1=6, found=2, more=1. out_valid 3 cycles after accept.
- Same r with lsb_first=1 -> slot0=4, slot1=6, found=2, more=1. r=12'b100000000001 -> slot0=12, slot1=1, more=0 in both modes, order swapped for lsb_first=1.
- r=12'b000000000000 -> found=0, p=0, more=0, out_valid 1 cycle after accept. r=12'b000010000000 -> slot0=8, slot1=0, found=1, latency 2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new r -> p/found/more stable, in_ready=0, no accept. After out_ready=1: IDLE next cycle, then the new r is accepted.
- Assert reset_n low mid-SCAN (N=16, K=4, r=16'hFFFF, after 2 SCAN cycles) -> immediately in_ready=1, out_valid=0, p=0, found=0. After release, r=16'h8421 gives slots 16,11,6,1, found=4, more=0, latency 5.
- K=N=12, r=12'hFFF, MSB-first -> slots 12 down to 1, found=12, more=0, latency 13.
